// File: rtl/seg7_pkg.sv
// seg7_pkg: digit-scan state encoding, output bundle type and hex-to-segment table.
package seg7_pkg;
    localparam logic [2:0] ST_BLANK = 3'd0;
    localparam logic [2:0] ST_D0    = 3'd1;
    localparam logic [2:0] ST_D1    = 3'd2;
    localparam logic [2:0] ST_D2    = 3'd3;
    localparam logic [2:0] ST_D3    = 3'd4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    localparam disp_t DISP_DARK = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

    // Active-low {g,f,e,d,c,b,a}; element 0 is the rightmost entry.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low 7-segment pattern.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = HEX_SEG[nib_i];
endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multiplexed 4-digit hex display with frame-aligned snapshot
// capture and optional leading-zero blanking.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        freeze,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done,
    output logic [15:0] snapshot
);
    localparam int DW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    state_q, state_d;
    logic [15:0]   snap_q, snap_d;
    disp_t         disp_q, disp_d;
    logic          fd_q, fd_d;
    logic          tick, enter_d0, dark;
    logic [1:0]    dig;
    logic [6:0]    nib_seg;

    assign tick     = div_q == DW'(REFRESH_DIV - 1);
    assign div_d    = tick ? '0 : div_q + 1'b1;
    assign state_d  = !tick ? state_q
                    : (state_q == ST_BLANK || state_q == ST_D3) ? ST_D0 : state_q + 3'd1;
    assign enter_d0 = tick && state_d == ST_D0;
    assign fd_d     = enter_d0;
    // The new snapshot feeds the decode directly so D0 shows the freshly captured value.
    assign snap_d   = enter_d0 && !freeze ? value_in : snap_q;
    assign dig      = 2'(state_d - ST_D0);
    assign dark     = state_d == ST_BLANK
                    || (BLANK_LEADING != 0 && dig != 2'd0 && (snap_d >> {dig, 2'b00}) == 16'd0);
    assign disp_d   = !tick ? disp_q
                    : dark  ? DISP_DARK
                    : {~(4'd1 << dig), nib_seg, ~dp_mask[dig]};

    hex_to_seg7 u_hex (
        .nib_i (snap_d[{dig, 2'b00} +: 4]),
        .seg_o (nib_seg)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q   <= '0;
            state_q <= ST_BLANK;
            snap_q  <= '0;
            disp_q  <= DISP_DARK;
            fd_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            snap_q  <= snap_d;
            disp_q  <= disp_d;
            fd_q    <= fd_d;
        end
    end

    assign an         = disp_q.an;
    assign seg        = disp_q.seg;
    assign dp         = disp_q.dp;
    assign frame_done = fd_q;
    assign snapshot   = snap_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: scoreboard bench; stimulus queues expected frames, a monitor
// checks each frame slot-by-slot as the display scans.
module tb_seg7_scan_display;
    localparam int NF = 9;
    localparam logic [11:0] DK = 12'hFFF;

    typedef struct packed {
        logic [15:0]      snap;
        logic [3:0][11:0] s;
        logic             c2;
        logic [3:0][11:0] t;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_in = 16'h0;
    logic        freeze = 1'b0;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  an, an2;
    logic [6:0]  seg, seg2;
    logic        dp, dp2, fd, fd2;
    logic [15:0] snap, snap2;

    frame_t q[$];
    int compared = 0;
    int mismatched = 0;
    int frames_checked = 0;

    always #5 clk = ~clk;

    seg7_scan_display #(.REFRESH_DIV(4), .BLANK_LEADING(1)) dut (
        .clock(clk), .reset(reset), .value_in(value_in), .freeze(freeze), .dp_mask(dp_mask),
        .an(an), .seg(seg), .dp(dp), .frame_done(fd), .snapshot(snap)
    );

    seg7_scan_display #(.REFRESH_DIV(4), .BLANK_LEADING(0)) dut2 (
        .clock(clk), .reset(reset), .value_in(value_in), .freeze(freeze), .dp_mask(dp_mask),
        .an(an2), .seg(seg2), .dp(dp2), .frame_done(fd2), .snapshot(snap2)
    );

    function automatic logic [11:0] sl(input logic [3:0] a, input logic [6:0] s, input logic d);
        return {a, s, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd && n < 64);
        chk("frame_start", 32'(fd), 32'd1);
    endtask

    task automatic push(input logic [15:0] v, input logic fr, input logic [3:0] dm,
                        input logic [15:0] sn, input logic [11:0] a0, a1, a2, a3,
                        input logic c2, input logic [11:0] b0, b1, b2, b3);
        frame_t f;
        value_in = v;
        freeze   = fr;
        dp_mask  = dm;
        f.snap = sn;
        f.s    = {a3, a2, a1, a0};
        f.c2   = c2;
        f.t    = {b3, b2, b1, b0};
        q.push_back(f);
    endtask

    // Changes value_in during D1 (must not show), then sets up the next frame during D3.
    task automatic next_frame(input logic [15:0] v, input logic fr, input logic [3:0] dm,
                              input logic [15:0] sn, input logic [11:0] a0, a1, a2, a3,
                              input logic c2, input logic [11:0] b0, b1, b2, b3);
        wait_fd();
        repeat (5) @(posedge clk);
        #1 value_in = ~value_in;
        freeze = 1'b0;
        repeat (8) @(posedge clk);
        #1 push(v, fr, dm, sn, a0, a1, a2, a3, c2, b0, b1, b2, b3);
    endtask

    initial begin : monitor
        frame_t f;
        while (frames_checked < NF) begin
            wait_fd();
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL scoreboard: frame seen with empty queue at %0t", $time);
                frames_checked = NF;
            end else begin
                f = q.pop_front();
                chk("snapshot", 32'(snap), 32'(f.snap));
                for (int k = 0; k < 4; k++) begin
                    if (k == 1) begin
                        @(negedge clk);
                        chk("frame_done_pulse", 32'(fd), 32'd0);
                        repeat (3) @(negedge clk);
                    end else if (k > 1) begin
                        repeat (4) @(negedge clk);
                    end
                    chk($sformatf("frame%0d_digit%0d", frames_checked, k),
                        32'(sl(an, seg, dp)), 32'(f.s[k]));
                    if (f.c2)
                        chk($sformatf("noblank_frame%0d_digit%0d", frames_checked, k),
                            32'(sl(an2, seg2, dp2)), 32'(f.t[k]));
                end
                frames_checked++;
            end
        end
    end

    initial begin : stimulus
        int n;
        push(16'h1A3F, 0, 4'b0000, 16'h1A3F,
             sl(4'hE, 7'h0E, 1), sl(4'hD, 7'h30, 1), sl(4'hB, 7'h08, 1), sl(4'h7, 7'h79, 1),
             0, DK, DK, DK, DK);
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", 32'(sl(an, seg, dp)), 32'(DK));
        chk("reset_frame_done", 32'(fd), 32'd0);
        chk("reset_snapshot", 32'(snap), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("blank_cycle%0d", i), 32'({sl(an, seg, dp), fd}), 32'({DK, 1'b0}));
        end
        next_frame(16'h0005, 0, 4'b0000, 16'h0005,
                   sl(4'hE, 7'h12, 1), DK, DK, DK,
                   1, sl(4'hE, 7'h12, 1), sl(4'hD, 7'h40, 1), sl(4'hB, 7'h40, 1), sl(4'h7, 7'h40, 1));
        next_frame(16'h0000, 0, 4'b0000, 16'h0000,
                   sl(4'hE, 7'h40, 1), DK, DK, DK, 0, DK, DK, DK, DK);
        next_frame(16'h1234, 0, 4'b0100, 16'h1234,
                   sl(4'hE, 7'h19, 1), sl(4'hD, 7'h30, 1), sl(4'hB, 7'h24, 0), sl(4'h7, 7'h79, 1),
                   0, DK, DK, DK, DK);
        next_frame(16'hFFFF, 1, 4'b0100, 16'h1234,
                   sl(4'hE, 7'h19, 1), sl(4'hD, 7'h30, 1), sl(4'hB, 7'h24, 0), sl(4'h7, 7'h79, 1),
                   0, DK, DK, DK, DK);
        next_frame(16'hFFFF, 1, 4'b0001, 16'h1234,
                   sl(4'hE, 7'h19, 0), sl(4'hD, 7'h30, 1), sl(4'hB, 7'h24, 1), sl(4'h7, 7'h79, 1),
                   0, DK, DK, DK, DK);
        next_frame(16'h0005, 0, 4'b0100, 16'h0005,
                   sl(4'hE, 7'h12, 1), DK, DK, DK,
                   1, sl(4'hE, 7'h12, 1), sl(4'hD, 7'h40, 1), sl(4'hB, 7'h40, 0), sl(4'h7, 7'h40, 1));
        next_frame(16'h0300, 0, 4'b1000, 16'h0300,
                   sl(4'hE, 7'h40, 1), sl(4'hD, 7'h40, 1), sl(4'hB, 7'h30, 1), DK,
                   0, DK, DK, DK, DK);
        next_frame(16'hC0DE, 0, 4'b1111, 16'hC0DE,
                   sl(4'hE, 7'h06, 0), sl(4'hD, 7'h21, 0), sl(4'hB, 7'h40, 0), sl(4'h7, 7'h46, 0),
                   0, DK, DK, DK, DK);
        n = 0;
        while (frames_checked < NF && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("frames_checked", 32'(frames_checked), 32'(NF));
        wait_fd();
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midscan_reset_outputs", 32'(sl(an, seg, dp)), 32'(DK));
        chk("midscan_reset_frame_done", 32'(fd), 32'd0);
        chk("midscan_reset_snapshot", 32'(snap), 32'd0);
        reset = 1'b0;
        value_in = 16'hBEEF;
        dp_mask = 4'b0000;
        freeze = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("restart_blank%0d", i), 32'({sl(an, seg, dp), fd}), 32'({DK, 1'b0}));
        end
        @(negedge clk);
        chk("restart_digit0", 32'(sl(an, seg, dp)), 32'(sl(4'hE, 7'h0E, 1)));
        chk("restart_frame_done", 32'(fd), 32'd1);
        chk("restart_snapshot", 32'(snap), 32'hBEEF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
